// File: rtl/slon_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// slon_ram_arb_pkg
// Shared types and parameter defaults for the two-port single-port-RAM arbiter.
//   state_t : arbiter FSM states (IDLE, OWN0, OWN1)
//   port_t  : requester identifier (PORT0 / PORT1)
// Helper functions map a port to its peer and to its ownership state.
// -----------------------------------------------------------------------------
package slon_ram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_MAX_BURST  = 4;

    // Wide enough for MAX_BURST up to 15.
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    function automatic port_t other_port(input port_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

    function automatic state_t own_state(input port_t p);
        return (p == PORT0) ? ST_OWN0 : ST_OWN1;
    endfunction

endpackage

// File: rtl/slon_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// slon_rd_tag_pipe
// Tracks accepted reads through the RAM latency and steers the returning RAM
// data to the port that issued the read.
// Stages 0..RD_LAT-1 follow the RAM pipeline; when stage RD_LAT-1 is valid,
// ram_douta belongs to that read and is captured into the owner's rdata
// register. Stage RD_LAT drives rvalid in the same cycle the data is visible.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_vld, in_port     : read accepted this cycle and by which port
//   ram_douta           : RAM read data
//   p0/p1_rvalid        : one-cycle read-data-valid per port
//   p0/p1_rdata         : registered read data per port
// -----------------------------------------------------------------------------
module slon_rd_tag_pipe
    import slon_ram_arb_pkg::*;
#(
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  port_t                 in_port,
    input  logic [DATA_WIDTH-1:0] ram_douta,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata
);

    logic  vld_q  [RD_LAT+1];
    port_t port_q [RD_LAT+1];

    // NOTE: this tag pipeline is control state, so every stage is reset;
    // otherwise a read in flight at reset would surface as rvalid afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                port_q[i] <= PORT0;
            end
        end else begin
            vld_q[0]  <= in_vld;
            port_q[0] <= in_port;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
            end
        end
    end

    // Capture RAM data only for the port whose read is due; the other port
    // keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (vld_q[RD_LAT-1]) begin
            if (port_q[RD_LAT-1] == PORT0) begin
                p0_rdata <= ram_douta;
            end else begin
                p1_rdata <= ram_douta;
            end
        end
    end

    assign p0_rvalid = vld_q[RD_LAT] && (port_q[RD_LAT] == PORT0);
    assign p1_rvalid = vld_q[RD_LAT] && (port_q[RD_LAT] == PORT1);

endmodule

// File: rtl/slon_ram_arb.sv
// -----------------------------------------------------------------------------
// slon_ram_arb
// Two-port arbiter in front of a single-port RAM with lockable ownership and
// a burst limit that protects the waiting port.
// Configuration macro: SLON_RAM_ARB_RR_EN
//   defined   : IDLE ties go to the port not granted last (round robin)
//   undefined : IDLE ties always go to p0
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   pN_req/lock/we/addr/wdata       : per-port access request
//   pN_gnt                          : access accepted this cycle (combinational)
//   pN_rvalid/rdata                 : read response, RD_LAT+1 cycles after accept
//   ram_ena/wea/addra/dina/douta    : single-port RAM interface
// -----------------------------------------------------------------------------
module slon_ram_arb
    import slon_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_lock,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_lock,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta
);

`ifdef SLON_RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BURST);

    state_t                 state_q, state_d;
    logic   [CNT_WIDTH-1:0] cnt_q, cnt_d;
    port_t                  last_q;
    // Set for one IDLE cycle after a burst is cut short, so the waiting port
    // wins the next tie even under fixed priority.
    logic                   yield_q, yield_d;

    logic  gnt0, gnt1;
    logic  acc;
    port_t win;
    port_t tie_port;
    logic  win_lock;
    logic  win_we;
    logic  other_req;
    logic  continuing;
    logic  forced;

    assign tie_port = (RR_EN || yield_q) ? other_port(last_q) : PORT0;

    // Owner has used up its burst and the other port is waiting: nobody is
    // granted this cycle and ownership is dropped.
    assign forced = ((state_q == ST_OWN0) && p0_req && p1_req && (cnt_q >= MAX_CNT)) ||
                    ((state_q == ST_OWN1) && p1_req && p0_req && (cnt_q >= MAX_CNT));

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ST_OWN0: begin
                if (p0_req) begin
                    gnt0 = !forced;
                end else begin
                    gnt1 = p1_req;
                end
            end
            ST_OWN1: begin
                if (p1_req) begin
                    gnt1 = !forced;
                end else begin
                    gnt0 = p0_req;
                end
            end
            default: begin
                if (p0_req && p1_req) begin
                    gnt0 = (tie_port == PORT0);
                    gnt1 = (tie_port == PORT1);
                end else begin
                    gnt0 = p0_req;
                    gnt1 = p1_req;
                end
            end
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign acc        = gnt0 | gnt1;
    assign win        = gnt1 ? PORT1 : PORT0;
    assign win_lock   = gnt1 ? p1_lock : p0_lock;
    assign win_we     = gnt1 ? p1_we : p0_we;
    assign other_req  = gnt1 ? p0_req : p1_req;
    assign continuing = (state_q == own_state(win));

    // Ownership is only ever entered or extended by a locked acceptance;
    // every other outcome returns to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        yield_d = 1'b0;
        if (acc) begin
            if (win_lock) begin
                if (!continuing) begin
                    cnt_d = CNT_WIDTH'(1);
                end else if (cnt_q >= MAX_CNT) begin
                    cnt_d = MAX_CNT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if ((cnt_d >= MAX_CNT) && other_req) begin
                    cnt_d   = '0;
                    yield_d = 1'b1;
                end else begin
                    state_d = own_state(win);
                end
            end
        end else if (forced) begin
            yield_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= PORT1;
            yield_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            yield_q <= yield_d;
            if (acc) begin
                last_q <= win;
            end
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign ram_ena   = acc;
    assign ram_wea   = acc & win_we;
    assign ram_addra = gnt1 ? p1_addr : p0_addr;
    assign ram_dina  = gnt1 ? p1_wdata : p0_wdata;

    slon_rd_tag_pipe #(
        .RD_LAT     (RD_LAT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (acc & ~win_we),
        .in_port   (win),
        .ram_douta (ram_douta),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata)
    );

endmodule

// File: tb/tb_slon_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_slon_ram_arb
// Self-checking bench for slon_ram_arb with default parameters. A cycle table
// drives both ports and holds the expected grants; RAM-side expectations and
// read responses follow from a shadow memory and a response queue.
// Honours SLON_RAM_ARB_RR_EN for the tie expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slon_ram_arb;

    localparam int AW        = 4;
    localparam int DW        = 8;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;

`ifdef SLON_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_lock, p0_we, p1_req, p1_lock, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_ena, ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina, ram_douta;

    always #5 clk = ~clk;

    slon_ram_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LAT     (RD_LAT),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_lock   (p0_lock),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p1_req    (p1_req),
        .p1_lock   (p1_lock),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 3) ? 8'hA5 : DW'(a * 7 + 33);
    endfunction

    // RAM model: synchronous read, RD_LAT cycles, read-before-write.
    logic [DW-1:0] mem     [16];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (ram_ena) begin
            if (ram_wea) mem[ram_addra] <= ram_dina;
            rd_pipe[0] <= mem[ram_addra];
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_douta = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected read responses.
    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t          sb [$];
    logic [DW-1:0] ref_mem [16];

    task automatic sb_observe(input logic port, input logic [DW-1:0] rd);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_unexpected: port %0d rdata %0h, no read outstanding", port, rd);
        end else begin
            e = sb.pop_front();
            check("rv_port", 32'(port), 32'(e.port));
            check("rdata", 32'(rd), 32'(e.data));
            check("rv_cycle", cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (p0_rvalid) sb_observe(1'b0, p0_rdata);
            if (p1_rvalid) sb_observe(1'b1, p1_rdata);
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL rvalid_missing: port %0d due cycle %0d, not observed by %0d",
                         sb[0].port, sb[0].due, cyc);
                void'(sb.pop_front());
            end
        end
    end

    typedef struct {
        logic          r0, l0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, l1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0, g1;
    } vec_t;

    function automatic vec_t mk(input logic r0, l0, w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0,
                                input logic r1, l1, w1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d1, input logic g0, g1);
        vec_t v;
        v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic drive_idle();
        p0_req = 0; p0_lock = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_lock = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic          ea, ew;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ed;
        @(negedge clk);
        p0_req = v.r0; p0_lock = v.l0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_lock = v.l1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
        #1;
        ea    = v.g0 | v.g1;
        ew    = v.g1 ? v.w1 : v.w0;
        eaddr = v.g1 ? v.a1 : v.a0;
        ed    = v.g1 ? v.d1 : v.d0;
        check($sformatf("v%0d.p0_gnt", idx), 32'(p0_gnt), 32'(v.g0));
        check($sformatf("v%0d.p1_gnt", idx), 32'(p1_gnt), 32'(v.g1));
        check($sformatf("v%0d.ram_ena", idx), 32'(ram_ena), 32'(ea));
        check($sformatf("v%0d.ram_wea", idx), 32'(ram_wea), 32'(ea & ew));
        if (ea) begin
            check($sformatf("v%0d.ram_addra", idx), 32'(ram_addra), 32'(eaddr));
            if (ew) begin
                check($sformatf("v%0d.ram_dina", idx), 32'(ram_dina), 32'(ed));
                ref_mem[eaddr] = ed;
            end else begin
                sb.push_back('{port: v.g1, data: ref_mem[eaddr], due: cyc + RD_LAT + 1});
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".p0_gnt"}, 32'(p0_gnt), 0);
        check({tag, ".p1_gnt"}, 32'(p1_gnt), 0);
        check({tag, ".ram_ena"}, 32'(ram_ena), 0);
        check({tag, ".ram_wea"}, 32'(ram_wea), 0);
        check({tag, ".p0_rvalid"}, 32'(p0_rvalid), 0);
        check({tag, ".p1_rvalid"}, 32'(p1_rvalid), 0);
        check({tag, ".p0_rdata"}, 32'(p0_rdata), 0);
        check({tag, ".p1_rdata"}, 32'(p1_rdata), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [$];

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        drive_idle();
        // Requests held high through reset: grants must still be forced low.
        p0_req = 1; p1_req = 1;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        drive_idle();
        @(negedge clk);
        rst = 0;

        // r0 l0 w0 a0 d0 | r1 l1 w1 a1 d1 | g0 g1
        vecs.push_back(mk(1,0,0, 3, 8'h00, 0,0,0, 0, 8'h00, 1, 0));      // p0 reads 0xA5
        vecs.push_back(mk(0,0,0, 0, 8'h00, 0,0,0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0,0,0, 0, 8'h00, 0,0,0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0,0,0, 0, 8'h00, 1,0,1, 15, 8'h3C, 0, 1));     // p1 write
        vecs.push_back(mk(0,0,0, 0, 8'h00, 1,0,0, 15, 8'h00, 0, 1));     // p1 read back
        vecs.push_back(mk(1,0,0, 1, 8'h00, 1,0,0, 2, 8'h00, 1, 0));      // ties
        vecs.push_back(mk(1,0,0, 1, 8'h00, 1,0,0, 2, 8'h00, !RR, RR));
        vecs.push_back(mk(1,0,0, 1, 8'h00, 1,0,0, 2, 8'h00, 1, 0));
        vecs.push_back(mk(1,0,0, 1, 8'h00, 1,0,0, 2, 8'h00, !RR, RR));
        vecs.push_back(mk(0,0,0, 0, 8'h00, 0,0,0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0,0,0, 0, 8'h00, 1,1,0, 4, 8'h00, 0, 1));      // p1 locks
        vecs.push_back(mk(1,0,0, 6, 8'h00, 1,1,0, 5, 8'h00, 0, 1));
        vecs.push_back(mk(1,0,0, 6, 8'h00, 1,1,0, 5, 8'h00, 0, 1));
        vecs.push_back(mk(1,0,0, 6, 8'h00, 1,1,0, 5, 8'h00, 0, 1));      // 4th p1 grant
        vecs.push_back(mk(1,0,0, 6, 8'h00, 1,1,0, 5, 8'h00, 1, 0));      // p0 wins
        vecs.push_back(mk(0,0,0, 0, 8'h00, 1,1,0, 5, 8'h00, 0, 1));      // p1 owns
        vecs.push_back(mk(1,0,0, 7, 8'h00, 0,0,0, 0, 8'h00, 1, 0));      // owner drops req
        vecs.push_back(mk(0,0,0, 0, 8'h00, 0,0,0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 5; i++)                                      // counter holds
            vecs.push_back(mk(1,1,0, AW'(8 + i), 8'h00, 0,0,0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1,1,0, 13, 8'h00, 1,0,0, 9, 8'h00, 0, 0));     // forced release
        vecs.push_back(mk(1,1,0, 13, 8'h00, 1,0,0, 9, 8'h00, 0, 1));     // p1 wins
        vecs.push_back(mk(1,0,0, 13, 8'h00, 1,0,0, 9, 8'h00, 1, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        @(negedge clk);
        drive_idle();
        repeat (RD_LAT + 3) @(negedge clk);
        @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        // Reset one cycle after a read acceptance: the read must vanish.
        @(negedge clk);
        p0_req = 1; p0_addr = 3;
        #1;
        check("rst_seq.p0_gnt", 32'(p0_gnt), 1);
        @(negedge clk);
        p0_req = 1; p1_req = 1;
        rst = 1;
        #1;
        check_all_zero("rst_seq.in_reset");
        @(negedge clk);
        #1;
        check_all_zero("rst_seq.in_reset2");
        drive_idle();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_seq.p0_rvalid%0d", i), 32'(p0_rvalid), 0);
            check($sformatf("rst_seq.p1_rvalid%0d", i), 32'(p1_rvalid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
